// File: rtl/player_input_conditioner.sv
`default_nettype none
// ============================================================================
// player_input_conditioner
//   Synchronizes and debounces the two active-low player buttons and emits a
//   one-cycle L / R step pulse per debounced press, gated by game_en.
//   Revision: 1.0
// ============================================================================
module player_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic KEY_L,
  input  logic KEY_R,
  input  logic game_en,
  output logic L,
  output logic R,
  output logic L_lvl,
  output logic R_lvl
);

  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  // Channel 0 is left, channel 1 is right.
  logic [1:0]            w_key_n;
  logic [1:0]            r_s1;
  logic [1:0]            r_s2;
  logic [1:0]            r_db;
  logic [1:0]            r_pulse;
  logic [1:0][CNT_W-1:0] r_cnt;

  assign w_key_n = {KEY_R, KEY_L};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_db    <= '0;
      r_pulse <= '0;
      r_cnt   <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        r_s1[i]    <= ~w_key_n[i];
        r_s2[i]    <= r_s1[i];
        r_pulse[i] <= 1'b0;
        if (r_s2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == c_CNT_LAST) begin
          r_db[i]    <= r_s2[i];
          r_cnt[i]   <= '0;
          // Only a press edge that lands while play is enabled becomes a step.
          r_pulse[i] <= r_s2[i] & game_en;
        end else begin
          r_cnt[i] <= r_cnt[i] + c_CNT_ONE;
        end
      end
    end
  end

  assign L     = r_pulse[0];
  assign R     = r_pulse[1];
  assign L_lvl = r_db[0];
  assign R_lvl = r_db[1];

endmodule
`default_nettype wire

// File: tb/tb_player_input_conditioner.sv
`default_nettype none
// tb_player_input_conditioner: directed stimulus pushes expected pulses into a
// queue; an independent monitor pops and compares whenever L or R is high.
module tb_player_input_conditioner;

  logic clk = 1'b0;
  logic reset;
  logic KEY_L;
  logic KEY_R;
  logic game_en;
  logic L;
  logic R;
  logic L_lvl;
  logic R_lvl;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int   cyc;
    logic l;
    logic r;
  } exp_t;

  exp_t q[$];
  exp_t m_e;

  player_input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .KEY_L   (KEY_L),
    .KEY_R   (KEY_R),
    .game_en (game_en),
    .L       (L),
    .R       (R),
    .L_lvl   (L_lvl),
    .R_lvl   (R_lvl)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every pulse cycle must match the head of the expectation queue.
  always @(posedge clk) begin
    #1;
    if (L || R) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse cyc=%0d got L=%0b R=%0b, required no pulse", cyc, L, R);
      end else begin
        m_e = q.pop_front();
        if (cyc != m_e.cyc || L !== m_e.l || R !== m_e.r) begin
          fails++;
          $display("FAIL pulse cyc=%0d got L=%0b R=%0b, required cyc=%0d L=%0b R=%0b",
                   cyc, L, R, m_e.cyc, m_e.l, m_e.r);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0b, required %0b", name, act, exp);
    end
  endtask

  task automatic push(input int c, input logic l, input logic r);
    exp_t e;
    e.cyc = c;
    e.l   = l;
    e.r   = r;
    q.push_back(e);
  endtask

  initial begin
    reset   = 1'b0;
    KEY_L   = 1'b1;
    KEY_R   = 1'b1;
    game_en = 1'b1;
    step(2);
    chk("rst_L", L, 1'b0);
    chk("rst_R", R, 1'b0);
    chk("rst_L_lvl", L_lvl, 1'b0);
    chk("rst_R_lvl", R_lvl, 1'b0);
    reset = 1'b1;
    step(3);

    // Clean left press and release
    KEY_L = 1'b0;
    push(cyc + 6, 1'b1, 1'b0);
    step(5);
    chk("press_lvl_before", L_lvl, 1'b0);
    step(1);
    chk("press_lvl_after", L_lvl, 1'b1);
    step(14);
    chk("press_lvl_held", L_lvl, 1'b1);
    chk("press_R_lvl_idle", R_lvl, 1'b0);
    KEY_L = 1'b1;
    step(5);
    chk("release_lvl_before", L_lvl, 1'b1);
    step(1);
    chk("release_lvl_after", L_lvl, 1'b0);
    step(6);

    // Bouncing right press
    KEY_R = 1'b0; step(1);
    KEY_R = 1'b1; step(1);
    KEY_R = 1'b0; step(1);
    KEY_R = 1'b1; step(1);
    KEY_R = 1'b0;
    push(cyc + 6, 1'b0, 1'b1);
    step(5);
    chk("bounce_lvl_before", R_lvl, 1'b0);
    step(1);
    chk("bounce_lvl_after", R_lvl, 1'b1);
    step(6);
    KEY_R = 1'b1;
    step(12);
    chk("bounce_released", R_lvl, 1'b0);

    // Three-cycle glitch must not register
    KEY_L = 1'b0;
    step(3);
    KEY_L = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("glitch_lvl", L_lvl, 1'b0);
    end

    // Simultaneous press
    KEY_L = 1'b0;
    KEY_R = 1'b0;
    push(cyc + 6, 1'b1, 1'b1);
    step(20);
    chk("simul_L_lvl", L_lvl, 1'b1);
    chk("simul_R_lvl", R_lvl, 1'b1);
    KEY_L = 1'b1;
    KEY_R = 1'b1;
    step(12);

    // Press while disabled is lost; re-press after enable pulses once
    game_en = 1'b0;
    KEY_L   = 1'b0;
    step(10);
    chk("gate_lvl_disabled", L_lvl, 1'b1);
    game_en = 1'b1;
    step(10);
    chk("gate_lvl_enabled", L_lvl, 1'b1);
    KEY_L = 1'b1;
    step(12);
    chk("gate_released", L_lvl, 1'b0);
    KEY_L = 1'b0;
    push(cyc + 6, 1'b1, 1'b0);
    step(12);
    KEY_L = 1'b1;
    step(12);

    // Asynchronous reset mid-operation, keys held through release
    KEY_L = 1'b0;
    push(cyc + 6, 1'b1, 1'b0);
    step(10);
    KEY_R = 1'b0;
    step(3);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_L_lvl", L_lvl, 1'b0);
    chk("async_rst_R_lvl", R_lvl, 1'b0);
    chk("async_rst_L", L, 1'b0);
    chk("async_rst_R", R, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    push(cyc + 6, 1'b1, 1'b1);
    step(12);
    chk("post_rst_L_lvl", L_lvl, 1'b1);
    chk("post_rst_R_lvl", R_lvl, 1'b1);
    KEY_L = 1'b1;
    KEY_R = 1'b1;
    step(12);

    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL missing_pulses: got %0d outstanding, required 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
